// File: rtl/lc3b_types.sv
// Shared LC-3b types, including the arbiter state and port identifiers.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } arb_port_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter for per-port grant statistics; sticks at all-ones.
module arb_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter with alternating priority on contention,
// grant counters and a sticky downstream-timeout flag.
//
// state   | meaning
// IDLE    | no transaction outstanding; arbitrate A/B requests
// SERVE_A | port A's latched request is driven downstream, waiting pmem_resp
// SERVE_B | port B's latched request is driven downstream, waiting pmem_resp
module mem_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read_a,
    input  logic              mem_write_a,
    input  logic [1:0]        mem_wmask_a,
    input  logic [ADDR_W-1:0] mem_address_a,
    input  logic [DATA_W-1:0] mem_wdata_a,
    output logic              mem_resp_a,
    output logic [DATA_W-1:0] mem_rdata_a,
    input  logic              mem_read_b,
    input  logic              mem_write_b,
    input  logic [1:0]        mem_wmask_b,
    input  logic [ADDR_W-1:0] mem_address_b,
    input  logic [DATA_W-1:0] mem_wdata_b,
    output logic              mem_resp_b,
    output logic [DATA_W-1:0] mem_rdata_b,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [1:0]        pmem_wmask,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [DATA_W-1:0] pmem_rdata,
    output logic [CNT_W-1:0]  grant_count_a,
    output logic [CNT_W-1:0]  grant_count_b,
    output logic              timeout_err
);
    import lc3b_types::*;

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    arb_state_t        state, state_next;
    arb_port_t         last_grant, grant_port;
    logic              grant;
    logic              req_a, req_b;
    logic              lat_read, lat_write;
    logic [1:0]        lat_wmask;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [TO_W-1:0]   to_cnt;

    assign req_a = mem_read_a | mem_write_a;
    assign req_b = mem_read_b | mem_write_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_port = PORT_A;
        unique case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    grant      = 1'b1;
                    grant_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
                end else if (req_b) begin
                    grant      = 1'b1;
                    grant_port = PORT_B;
                end else if (req_a) begin
                    grant      = 1'b1;
                    grant_port = PORT_A;
                end
                if (grant) state_next = (grant_port == PORT_B) ? SERVE_B : SERVE_A;
            end
            SERVE_A, SERVE_B: if (pmem_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wmask   = '0;
        pmem_address = '0;
        pmem_wdata   = '0;
        mem_resp_a   = 1'b0;
        mem_rdata_a  = '0;
        mem_resp_b   = 1'b0;
        mem_rdata_b  = '0;
        if (state != IDLE) begin
            pmem_read    = lat_read;
            pmem_write   = lat_write;
            pmem_wmask   = lat_wmask;
            pmem_address = lat_addr;
            pmem_wdata   = lat_wdata;
        end
        if (state == SERVE_A && pmem_resp) begin
            mem_resp_a  = 1'b1;
            mem_rdata_a = pmem_rdata;
        end
        if (state == SERVE_B && pmem_resp) begin
            mem_resp_b  = 1'b1;
            mem_rdata_b = pmem_rdata;
        end
    end

    // Write wins when a requester raises both strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= PORT_A;
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
            lat_wmask  <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (grant) begin
            last_grant <= grant_port;
            if (grant_port == PORT_B) begin
                lat_write <= mem_write_b;
                lat_read  <= mem_read_b & ~mem_write_b;
                lat_wmask <= mem_wmask_b;
                lat_addr  <= mem_address_b;
                lat_wdata <= mem_wdata_b;
            end else begin
                lat_write <= mem_write_a;
                lat_read  <= mem_read_a & ~mem_write_a;
                lat_wmask <= mem_wmask_a;
                lat_addr  <= mem_address_a;
                lat_wdata <= mem_wdata_a;
            end
        end
    end

    // Counter saturates at TIMEOUT; the flag rises on the edge it gets there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else if (!pmem_resp && (to_cnt != TO_MAX)) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (to_cnt == TO_MAX - TO_W'(1)) timeout_err <= 1'b1;
        end
    end

    arb_sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (grant && (grant_port == PORT_A)),
        .count   (grant_count_a)
    );

    arb_sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (grant && (grant_port == PORT_B)),
        .count   (grant_count_b)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 time unit after each rising
// edge, outputs are checked 1 unit later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_read_a, mem_write_a, mem_read_b, mem_write_b;
    logic [1:0]  mem_wmask_a, mem_wmask_b;
    logic [15:0] mem_address_a, mem_wdata_a, mem_address_b, mem_wdata_b;
    logic        mem_resp_a, mem_resp_b;
    logic [15:0] mem_rdata_a, mem_rdata_b;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [1:0]  pmem_wmask;
    logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
    logic [15:0] grant_count_a, grant_count_b;
    logic        timeout_err;

    int n_vec = 0;
    int n_mis = 0;

    mem_arbiter #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(255), .CNT_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_read_a    (mem_read_a),
        .mem_write_a   (mem_write_a),
        .mem_wmask_a   (mem_wmask_a),
        .mem_address_a (mem_address_a),
        .mem_wdata_a   (mem_wdata_a),
        .mem_resp_a    (mem_resp_a),
        .mem_rdata_a   (mem_rdata_a),
        .mem_read_b    (mem_read_b),
        .mem_write_b   (mem_write_b),
        .mem_wmask_b   (mem_wmask_b),
        .mem_address_b (mem_address_b),
        .mem_wdata_b   (mem_wdata_b),
        .mem_resp_b    (mem_resp_b),
        .mem_rdata_b   (mem_rdata_b),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_wmask    (pmem_wmask),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_resp     (pmem_resp),
        .pmem_rdata    (pmem_rdata),
        .grant_count_a (grant_count_a),
        .grant_count_b (grant_count_b),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read_a = 0; mem_write_a = 0; mem_wmask_a = 0; mem_address_a = 0; mem_wdata_a = 0;
        mem_read_b = 0; mem_write_b = 0; mem_wmask_b = 0; mem_address_b = 0; mem_wdata_b = 0;
        pmem_resp = 0; pmem_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        cyc();
    endtask

    initial begin
        reset_n = 0;
        clear_inputs();
        #2;
        mem_read_a = 1; mem_address_a = 16'h0777;
        #1;
        check_vec("rst_pmem_read", 32'(pmem_read), 0);
        check_vec("rst_pmem_addr", 32'(pmem_address), 0);
        check_vec("rst_cnt_a", 32'(grant_count_a), 0);
        check_vec("rst_timeout", 32'(timeout_err), 0);
        repeat (2) @(posedge clk);
        check_vec("rst_held_read", 32'(pmem_read), 0);
        clear_inputs();
        @(negedge clk);
        reset_n = 1;
        cyc();

        // pmem_resp while idle must not reach either port
        pmem_resp = 1; pmem_rdata = 16'hDEAD;
        #1;
        check_vec("idle_resp_a", 32'(mem_resp_a), 0);
        check_vec("idle_resp_b", 32'(mem_resp_b), 0);
        cyc();
        pmem_resp = 0;

        // single read on A, response 3 cycles after strobe
        mem_read_a = 1; mem_address_a = 16'h1234;
        #1;
        check_vec("t1_c0_read", 32'(pmem_read), 0);
        cyc();
        check_vec("t1_c1_read", 32'(pmem_read), 1);
        check_vec("t1_c1_addr", 32'(pmem_address), 'h1234);
        check_vec("t1_c1_resp_a", 32'(mem_resp_a), 0);
        cyc(); cyc(); cyc();
        pmem_resp = 1; pmem_rdata = 16'hBEEF;
        #1;
        check_vec("t1_resp_a", 32'(mem_resp_a), 1);
        check_vec("t1_rdata_a", 32'(mem_rdata_a), 'hBEEF);
        check_vec("t1_resp_b", 32'(mem_resp_b), 0);
        check_vec("t1_rdata_b", 32'(mem_rdata_b), 0);
        cyc();
        clear_inputs();
        #1;
        check_vec("t1_idle_read", 32'(pmem_read), 0);
        check_vec("t1_cnt_a", 32'(grant_count_a), 1);
        check_vec("t1_cnt_b", 32'(grant_count_b), 0);
        check_vec("t1_timeout", 32'(timeout_err), 0);

        // contention out of reset: B, then A, then B
        do_reset();
        mem_read_a = 1; mem_address_a = 16'h1000;
        mem_read_b = 1; mem_address_b = 16'h2000;
        #1;
        check_vec("t2_idle_read", 32'(pmem_read), 0);
        cyc();
        check_vec("t2_first_b", 32'(pmem_address), 'h2000);
        pmem_resp = 1; pmem_rdata = 16'h0B0B;
        #1;
        check_vec("t2_resp_b1", 32'(mem_resp_b), 1);
        check_vec("t2_rdata_b1", 32'(mem_rdata_b), 'h0B0B);
        check_vec("t2_resp_a0", 32'(mem_resp_a), 0);
        check_vec("t2_rdata_a0", 32'(mem_rdata_a), 0);
        cyc();
        pmem_resp = 0; mem_address_b = 16'h2002;
        #1;
        check_vec("t2_dead_cycle", 32'(pmem_read), 0);
        cyc();
        check_vec("t2_second_a", 32'(pmem_address), 'h1000);
        pmem_resp = 1; pmem_rdata = 16'h0A0A;
        #1;
        check_vec("t2_resp_a2", 32'(mem_resp_a), 1);
        check_vec("t2_resp_b2", 32'(mem_resp_b), 0);
        cyc();
        pmem_resp = 0;
        #1;
        check_vec("t2_dead_cycle2", 32'(pmem_read), 0);
        cyc();
        check_vec("t2_third_b", 32'(pmem_address), 'h2002);
        pmem_resp = 1;
        #1;
        check_vec("t2_resp_b3", 32'(mem_resp_b), 1);
        cyc();
        clear_inputs();
        #1;
        check_vec("t2_cnt_a", 32'(grant_count_a), 1);
        check_vec("t2_cnt_b", 32'(grant_count_b), 2);

        // write on B, inputs disturbed mid-transaction
        mem_write_b = 1; mem_wmask_b = 2'b01; mem_wdata_b = 16'h00AA; mem_address_b = 16'h3000;
        cyc();
        check_vec("t3_c1_write", 32'(pmem_write), 1);
        check_vec("t3_c1_read", 32'(pmem_read), 0);
        check_vec("t3_c1_wdata", 32'(pmem_wdata), 'h00AA);
        check_vec("t3_c1_wmask", 32'(pmem_wmask), 1);
        mem_wdata_b = 16'hFFFF; mem_wmask_b = 2'b10; mem_address_b = 16'h5555;
        cyc();
        check_vec("t3_c2_wdata", 32'(pmem_wdata), 'h00AA);
        check_vec("t3_c2_wmask", 32'(pmem_wmask), 1);
        check_vec("t3_c2_addr", 32'(pmem_address), 'h3000);
        check_vec("t3_c2_resp_a", 32'(mem_resp_a), 0);
        cyc();
        pmem_resp = 1;
        #1;
        check_vec("t3_resp_b", 32'(mem_resp_b), 1);
        check_vec("t3_resp_a", 32'(mem_resp_a), 0);
        check_vec("t3_resp_wdata", 32'(pmem_wdata), 'h00AA);
        cyc();
        clear_inputs();

        // read and write both high on A
        mem_read_a = 1; mem_write_a = 1; mem_address_a = 16'h4000;
        cyc();
        check_vec("t4_write", 32'(pmem_write), 1);
        check_vec("t4_read", 32'(pmem_read), 0);
        pmem_resp = 1;
        #1;
        check_vec("t4_resp_a", 32'(mem_resp_a), 1);
        cyc();
        clear_inputs();

        // reset while SERVE_A is waiting
        mem_read_a = 1; mem_address_a = 16'h6000;
        cyc();
        check_vec("t6_c1_read", 32'(pmem_read), 1);
        cyc();
        reset_n = 0; pmem_resp = 1; pmem_rdata = 16'h1111;
        #1;
        check_vec("t6_rst_read", 32'(pmem_read), 0);
        check_vec("t6_rst_addr", 32'(pmem_address), 0);
        check_vec("t6_rst_resp_a", 32'(mem_resp_a), 0);
        check_vec("t6_rst_rdata_a", 32'(mem_rdata_a), 0);
        check_vec("t6_rst_cnt_a", 32'(grant_count_a), 0);
        @(negedge clk);
        pmem_resp = 0;
        #2;
        reset_n = 1;
        #1;
        check_vec("t6_rel_idle", 32'(pmem_read), 0);
        cyc();
        check_vec("t6_regrant_read", 32'(pmem_read), 1);
        check_vec("t6_regrant_addr", 32'(pmem_address), 'h6000);
        check_vec("t6_regrant_cnt", 32'(grant_count_a), 1);
        pmem_resp = 1;
        #1;
        check_vec("t6_resp_a", 32'(mem_resp_a), 1);
        cyc();
        clear_inputs();

        // response withheld 256 cycles, TIMEOUT = 255
        mem_read_a = 1; mem_address_a = 16'h7000;
        cyc();
        check_vec("t5_c1_timeout", 32'(timeout_err), 0);
        for (int i = 2; i <= 256; i++) begin
            cyc();
            if (i == 255) check_vec("t5_before_limit", 32'(timeout_err), 0);
            if (i == 256) check_vec("t5_at_limit", 32'(timeout_err), 1);
        end
        check_vec("t5_still_waiting", 32'(pmem_read), 1);
        cyc();
        pmem_resp = 1; pmem_rdata = 16'h5A5A;
        #1;
        check_vec("t5_late_resp_a", 32'(mem_resp_a), 1);
        check_vec("t5_late_rdata_a", 32'(mem_rdata_a), 'h5A5A);
        cyc();
        clear_inputs();
        #1;
        check_vec("t5_sticky_idle", 32'(timeout_err), 1);
        cyc(); cyc();
        check_vec("t5_sticky_later", 32'(timeout_err), 1);
        @(negedge clk);
        reset_n = 0;
        #1;
        check_vec("t5_cleared_by_reset", 32'(timeout_err), 0);
        @(negedge clk);
        reset_n = 1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
